// File: rtl/bit_cmd_sequencer_pkg.sv
// rtl/bit_cmd_sequencer_pkg.sv - shared command record, issue FSM states and op encodings
package bitcmd_pkg;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    typedef struct packed {
        logic       op;
        logic [1:0] idx;
    } bit_cmd_t;

    typedef enum logic {
        IDLE,
        HOLD
    } issue_state_t;

endpackage

// File: rtl/bit_cmd_sequencer_if.sv
// rtl/bit_cmd_sequencer_if.sv - valid/ready command channel toward the set/clear register
// Signals: cmd_valid (command present), cmd_op (1 = set, 0 = clear),
//          cmd_idx (target bit), cmd_ready (downstream accepts this cycle).
// Modports: master drives the command, slave drives ready.
interface bit_cmd_sequencer_if #(
    parameter int IDX_W = 2
);
    logic             cmd_valid;
    logic             cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic             cmd_ready;

    modport master (output cmd_valid, output cmd_op, output cmd_idx, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_idx, output cmd_ready);
endinterface

// File: rtl/bit_cmd_sequencer_debounce.sv
// rtl/bit_cmd_sequencer_debounce.sv - per-button synchroniser, debouncer and press detector
// Ports: clk, rst (sync, active-high); i_raw asynchronous button level;
//        o_rise one-cycle pulse when the debounced level goes 0->1.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_rise
);
    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_db_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            // Counter only runs while the synced level disagrees with the accepted level;
            // any return to agreement restarts the qualification window.
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_db & ~r_db_d;
endmodule

// File: rtl/bit_cmd_sequencer.sv
// rtl/bit_cmd_sequencer.sv - pushbutton front end issuing {op, idx} set/clear commands
// Ports: clk, rst (sync, active-high); i_btn_raw[N_BTN] async buttons (1 = pressed);
//        i_set_sw async set/clear switch sampled at press; cmd_if command channel (master);
//        o_busy any command pending or presented; o_overrun one-cycle pulse when a press
//        lands on a button whose previous command is still outstanding.
module bit_cmd_sequencer
    import bitcmd_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_BTN-1:0]       i_btn_raw,
    input  logic                   i_set_sw,
    bit_cmd_sequencer_if.master    cmd_if,
    output logic                   o_busy,
    output logic                   o_overrun
);
    localparam int IDX_W = $clog2(N_BTN);

    logic             r_sw_s1;
    logic             r_sw_s2;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] r_pending;
    logic [N_BTN-1:0] r_pend_op;
    logic [N_BTN-1:0] w_pend_nxt;
    logic [N_BTN-1:0] w_op_nxt;
    logic [N_BTN-1:0] w_gnt_clr;
    logic             r_overrun;
    logic             w_ovr;

    issue_state_t     r_state;
    issue_state_t     w_state_nxt;
    bit_cmd_t         r_cmd;
    bit_cmd_t         w_cmd_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_nxt;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_accept;
    logic             w_gnt;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == N_BTN - 1) ? '0 : i + 1'b1;
    endfunction

    // First requesting index at or after base, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                                 input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] j;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            j = IDX_W'((int'(base) + k) % N_BTN);
            if (!found && req[j]) begin
                pick  = j;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (i_btn_raw[gi]),
            .o_rise (w_rise[gi])
        );
    end

    always_comb begin
        w_accept    = (r_state == HOLD) && cmd_if.cmd_ready;
        // A back-to-back grant already scans from the post-acceptance pointer.
        w_base      = w_accept ? wrap_inc(r_cmd.idx) : r_rr_ptr;
        w_gnt_idx   = rr_pick(r_pending, w_base);
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_rr_nxt    = r_rr_ptr;
        w_gnt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    w_rr_nxt = w_base;
                    if (|r_pending) w_gnt = 1'b1;
                    else            w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_gnt) begin
            w_cmd_nxt = '{op: r_pend_op[w_gnt_idx], idx: w_gnt_idx};
        end
        w_gnt_clr = w_gnt ? (N_BTN'(1) << w_gnt_idx) : '0;
    end

    // A new press always wins over a same-cycle grant clear. A command counts as
    // outstanding while pending or while presented and not yet accepted.
    always_comb begin
        w_ovr      = 1'b0;
        w_pend_nxt = r_pending & ~w_gnt_clr;
        w_op_nxt   = r_pend_op;
        for (int i = 0; i < N_BTN; i++) begin
            if (w_rise[i]) begin
                if (r_pending[i] ||
                    ((r_state == HOLD) && (r_cmd.idx == IDX_W'(i)) && !w_accept)) begin
                    w_ovr = 1'b1;
                end
                w_pend_nxt[i] = 1'b1;
                w_op_nxt[i]   = r_sw_s2 ? OP_SET : OP_CLR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_s1   <= 1'b0;
            r_sw_s2   <= 1'b0;
            r_state   <= IDLE;
            r_cmd     <= '{op: OP_CLR, idx: '0};
            r_rr_ptr  <= '0;
            r_pending <= '0;
            r_pend_op <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_sw_s1   <= i_set_sw;
            r_sw_s2   <= r_sw_s1;
            r_state   <= w_state_nxt;
            r_cmd     <= w_cmd_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_pending <= w_pend_nxt;
            r_pend_op <= w_op_nxt;
            r_overrun <= w_ovr;
        end
    end

    assign cmd_if.cmd_valid = (r_state == HOLD);
    assign cmd_if.cmd_op    = r_cmd.op;
    assign cmd_if.cmd_idx   = r_cmd.idx;
    assign o_busy           = (|r_pending) || (r_state == HOLD);
    assign o_overrun        = r_overrun;
endmodule

// File: tb/tb_bit_cmd_sequencer.sv
// tb/tb_bit_cmd_sequencer.sv - directed vector bench for bit_cmd_sequencer (DEB_CYCLES = 4)
module tb_bit_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       set_sw;
    logic       busy;
    logic       overrun;

    always #5 clk = ~clk;

    bit_cmd_sequencer_if cmd_if ();

    bit_cmd_sequencer #(
        .N_BTN      (4),
        .DEB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_btn_raw (btn_raw),
        .i_set_sw  (set_sw),
        .cmd_if    (cmd_if),
        .o_busy    (busy),
        .o_overrun (overrun)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // st: also require op/idx to match while cmd_valid is expected low (reset state).
    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] btn;
        logic       sw;
        logic       rdy;
        int         n;
        logic       st;
        logic       ev;
        logic       eo;
        logic [1:0] ei;
        logic       eb;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic [3:0] b, input logic sw,
                       input logic rdy, input int n, input logic st, input logic ev,
                       input logic eo, input logic [1:0] ei, input logic eb, input logic er);
        vec_t v;
        v.name = name; v.rst = r; v.btn = b; v.sw = sw; v.rdy = rdy; v.n = n;
        v.st = st; v.ev = ev; v.eo = eo; v.ei = ei; v.eb = eb; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic st, input logic ev, input logic eo,
                         input logic [1:0] ei, input logic eb, input logic er);
        logic ok;
        n_vec++;
        ok = (cmd_if.cmd_valid === ev) && (busy === eb) && (overrun === er);
        if (ev || st) ok = ok && (cmd_if.cmd_op === eo) && (cmd_if.cmd_idx === ei);
        if (!ok) begin
            n_miss++;
            $display("FAIL %s @%0t: got valid=%b op=%b idx=%0d busy=%b ovr=%b, want valid=%b op=%b idx=%0d busy=%b ovr=%b",
                     name, $time, cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_idx, busy, overrun,
                     ev, eo, ei, eb, er);
        end
    endtask

    task automatic run(input string name, input int n, input logic st, input logic ev,
                       input logic eo, input logic [1:0] ei, input logic eb, input logic er);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            check(name, st, ev, eo, ei, eb, er);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_raw = 4'b0000; set_sw = 1'b0; cmd_if.cmd_ready = 1'b1;
        run("reset", 2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        //   name           rst btn      sw  rdy  n  st valid op idx busy ovr
        add("rst_a",        1, 4'b1111, 1, 1,  1, 1, 0, 0, 2'd0, 0, 0);
        add("rst_b",        1, 4'b0101, 0, 1,  1, 1, 0, 0, 2'd0, 0, 0);
        add("rst_c",        1, 4'b1010, 1, 1,  1, 1, 0, 0, 2'd0, 0, 0);
        add("rst_quiet",    0, 4'b0000, 0, 1, 10, 1, 0, 0, 2'd0, 0, 0);
        add("press_wait",   0, 4'b0100, 1, 1,  6, 0, 0, 0, 2'd0, 0, 0);
        add("press_pend",   0, 4'b0100, 1, 1,  1, 0, 0, 0, 2'd0, 1, 0);
        add("press_issue",  0, 4'b0100, 1, 1,  1, 0, 1, 1, 2'd2, 1, 0);
        add("press_after",  0, 4'b0100, 1, 1,  4, 0, 0, 0, 2'd0, 0, 0);
        add("release",      0, 4'b0000, 1, 1, 12, 0, 0, 0, 2'd0, 0, 0);
        add("clr_wait",     0, 4'b1000, 0, 1,  6, 0, 0, 0, 2'd0, 0, 0);
        add("clr_pend",     0, 4'b1000, 0, 1,  1, 0, 0, 0, 2'd0, 1, 0);
        add("clr_issue",    0, 4'b1000, 0, 1,  1, 0, 1, 0, 2'd3, 1, 0);
        add("clr_release",  0, 4'b0000, 0, 1, 12, 0, 0, 0, 2'd0, 0, 0);
        add("bounce_hi",    0, 4'b0010, 1, 1,  3, 0, 0, 0, 2'd0, 0, 0);
        add("bounce_lo",    0, 4'b0000, 1, 1, 10, 0, 0, 0, 2'd0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; btn_raw = vecs[i].btn; set_sw = vecs[i].sw;
            cmd_if.cmd_ready = vecs[i].rdy;
            run(vecs[i].name, vecs[i].n, vecs[i].st, vecs[i].ev, vecs[i].eo, vecs[i].ei,
                vecs[i].eb, vecs[i].er);
        end

        // Simultaneous presses under backpressure: idx0 held, then idx3 back-to-back.
        do_reset();
        cmd_if.cmd_ready = 1'b0; set_sw = 1'b1; btn_raw = 4'b1001;
        run("sim_wait", 6, 0, 0, 0, 2'd0, 0, 0);
        run("sim_pend", 1, 0, 0, 0, 2'd0, 1, 0);
        run("sim_hold0", 5, 0, 1, 1, 2'd0, 1, 0);
        cmd_if.cmd_ready = 1'b1;
        run("sim_next3", 1, 0, 1, 1, 2'd3, 1, 0);
        run("sim_done", 1, 0, 0, 0, 2'd0, 0, 0);
        btn_raw = 4'b0000;
        run("sim_quiet", 8, 0, 0, 0, 2'd0, 0, 0);

        // Re-press of a button whose command is still presented.
        do_reset();
        cmd_if.cmd_ready = 1'b0; set_sw = 1'b1; btn_raw = 4'b0010;
        run("ovr_wait", 6, 0, 0, 0, 2'd0, 0, 0);
        run("ovr_pend", 1, 0, 0, 0, 2'd0, 1, 0);
        run("ovr_hold", 1, 0, 1, 1, 2'd1, 1, 0);
        btn_raw = 4'b0000;
        run("ovr_rel", 10, 0, 1, 1, 2'd1, 1, 0);
        set_sw = 1'b0; btn_raw = 4'b0010;
        run("ovr_repress", 6, 0, 1, 1, 2'd1, 1, 0);
        run("ovr_pulse", 1, 0, 1, 1, 2'd1, 1, 1);
        run("ovr_once", 3, 0, 1, 1, 2'd1, 1, 0);
        cmd_if.cmd_ready = 1'b1;
        run("ovr_newest", 1, 0, 1, 0, 2'd1, 1, 0);
        run("ovr_done", 1, 0, 0, 0, 2'd0, 0, 0);
        btn_raw = 4'b0000;
        run("ovr_quiet", 10, 0, 0, 0, 2'd0, 0, 0);

        // Reset while a command is presented and two more are pending.
        do_reset();
        cmd_if.cmd_ready = 1'b0; set_sw = 1'b1; btn_raw = 4'b1101;
        run("mid_wait", 6, 0, 0, 0, 2'd0, 0, 0);
        run("mid_pend", 1, 0, 0, 0, 2'd0, 1, 0);
        run("mid_hold", 1, 0, 1, 1, 2'd0, 1, 0);
        rst = 1'b1; btn_raw = 4'b0000;
        run("mid_rst", 1, 1, 0, 0, 2'd0, 0, 0);
        rst = 1'b0; cmd_if.cmd_ready = 1'b1;
        run("mid_after", 15, 1, 0, 0, 2'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
